// File: rtl/mips_trace_buffer_pkg.sv
// Shared debug package for the MIPS trace buffer.
// Holds the state encoding, capture mode constants and the opcode field slice.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } state_e;

    localparam logic [1:0] MODE_WRAP = 2'd0;
    localparam logic [1:0] MODE_STOP = 2'd1;
    localparam logic [1:0] MODE_TRIG = 2'd2;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;

    // Mode 3 is reserved and behaves like wrap.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_WRAP : m;
    endfunction

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Drain port of the trace buffer: valid/ready stream of {seq, pc, ir}.
// master = trace buffer (drives data/valid), slave = consumer (drives ready).
interface mips_trace_buffer_if #(
    parameter int DATA_W = 32,
    parameter int SEQ_W  = 16
) ();

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_ir;
    logic [SEQ_W-1:0]  out_seq;

    modport master (
        output out_valid,
        output out_pc,
        output out_ir,
        output out_seq,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_ir,
        input  out_seq,
        output out_ready
    );

endinterface

// File: rtl/mips_trace_buffer_trace_mem.sv
// Trace storage: DEPTH x W register array.
// Ports: clk, we/waddr/wdata (synchronous write), raddr/rdata (async read).
module trace_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 80,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mips_trace_buffer.sv
// Instruction-trace capture buffer for the single-cycle MIPS core.
// Ports: clk, rst (sync, active-low), en/mode/trig_op capture control,
// valid_in/pc_in/ir_in retire sample, dbg drain stream, count/overflow/
// triggered/frozen status.
module mips_trace_buffer
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int SEQ_W     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [5:0]               trig_op,
    input  logic                     valid_in,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic [DATA_W-1:0]        ir_in,
    mips_trace_buffer_if.master      dbg,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     triggered,
    output logic                     frozen
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int ENT_W = SEQ_W + 2 * DATA_W;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] PT   = CNT_W'(POST_TRIG);

    state_e             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic               overflow_q, overflow_d;
    logic               triggered_q, triggered_d;
    logic [CNT_W-1:0]   post_cnt_q, post_cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [5:0]         trig_op_q, trig_op_d;

    logic               we;
    logic               is_trig;
    logic [ENT_W-1:0]   rd_data;

    assign is_trig = (ir_in[OP_HI:OP_LO] == trig_op_q);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        seq_d       = seq_q;
        overflow_d  = overflow_q;
        triggered_d = triggered_q;
        post_cnt_d  = post_cnt_q;
        mode_d      = mode_q;
        trig_op_d   = trig_op_q;
        we          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d     = ST_RUN;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    count_d     = '0;
                    seq_d       = '0;
                    overflow_d  = 1'b0;
                    triggered_d = 1'b0;
                    post_cnt_d  = '0;
                    mode_d      = norm_mode(mode);
                    trig_op_d   = trig_op;
                end
            end

            ST_RUN: begin
                if (!en) begin
                    state_d = ST_FROZEN;
                end else if (valid_in) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    seq_d    = seq_q + SEQ_W'(1);

                    if (mode_q == MODE_STOP) begin
                        count_d = count_q + CNT_W'(1);
                        if (count_q == FULL - CNT_W'(1)) begin
                            state_d = ST_FROZEN;
                        end
                    end else if (count_q == FULL) begin
                        // Full in wrap/trigger mode: drop the oldest.
                        rd_ptr_d   = rd_ptr_q + AW'(1);
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end

                    // Only stores count toward the post-trigger window.
                    if (mode_q == MODE_TRIG) begin
                        if (triggered_q) begin
                            post_cnt_d = post_cnt_q + CNT_W'(1);
                            if (post_cnt_q == PT - CNT_W'(1)) begin
                                state_d = ST_FROZEN;
                            end
                        end else if (is_trig) begin
                            triggered_d = 1'b1;
                            if (PT == '0) begin
                                state_d = ST_FROZEN;
                            end
                        end
                    end
                end
            end

            ST_FROZEN: begin
                if (count_q == '0) begin
                    state_d = ST_IDLE;
                end else if (dbg.out_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    count_d  = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            seq_q       <= '0;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
            post_cnt_q  <= '0;
            mode_q      <= MODE_WRAP;
            trig_op_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            seq_q       <= seq_d;
            overflow_q  <= overflow_d;
            triggered_q <= triggered_d;
            post_cnt_q  <= post_cnt_d;
            mode_q      <= mode_d;
            trig_op_q   <= trig_op_d;
        end
    end

    trace_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata ({seq_q, pc_in, ir_in}),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign {dbg.out_seq, dbg.out_pc, dbg.out_ir} = rd_data;

    assign frozen        = (state_q == ST_FROZEN);
    assign dbg.out_valid = frozen && (count_q != '0);
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign triggered     = triggered_q;

endmodule
